// File: rtl/gen_share_arbiter.sv
// Round-robin sharing of one start/ready/valid/done generator core among NUM_REQ requesters.
// Each job re-resets the core, pulses start, then forwards its beats tagged with the owner id.
module gen_share_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DW             = 32,
  parameter int GEN_RST_CYCLES = 2,
  parameter int TIMEOUT        = 1024,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                  __clock,
  input  logic                  __reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_n,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  gen_reset,
  output logic                  gen_start,
  output logic [DW-1:0]         gen_n,
  output logic                  gen_ready,
  input  logic                  gen_valid,
  input  logic                  gen_done,
  input  logic [DW-1:0]         gen_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [IW-1:0]         out_id,
  output logic                  out_last,
  output logic                  out_err,
  output logic                  busy
);

  // state | meaning
  // IDLE  | core held in reset, waiting for a request to grant
  // GRST  | core reset held for GEN_RST_CYCLES cycles
  // LOAD  | core released, start pulsed with gen_n
  // RUN   | beats streamed through single-entry buffer, watchdog armed
  // DRAIN | core held off, waiting for final beat to leave the buffer
  typedef enum logic [2:0] {IDLE, GRST, LOAD, RUN, DRAIN} state_t;

  localparam int RW = $clog2(GEN_RST_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   job_id;
  logic [RW-1:0]   rst_cnt;
  logic [WW-1:0]   wd_cnt;
  logic            done_seen;
  logic            buf_full;
  logic [DW-1:0]   buf_data;
  logic [IW-1:0]   buf_id;
  logic            buf_last;
  logic            buf_err;

  logic            grant_any;
  logic [IW-1:0]   grant_idx;
  logic            cap;
  logic            cap_last;
  logic            abort;
  logic            drain;

  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    // Scan from the far end so the lowest offset from rr_ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IW'(idx);
      end
    end
  end

  assign abort    = (state == RUN) && (wd_cnt == '0) && !gen_valid && !buf_full;
  assign cap      = (state == RUN) && gen_valid && gen_ready;
  assign cap_last = done_seen || gen_done;
  assign drain    = buf_full && out_ready;

  always_ff @(posedge __clock or posedge __reset) begin
    if (__reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = GRST;
      GRST:    if (rst_cnt == '0) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if ((cap && cap_last) || abort) state_nxt = DRAIN;
      DRAIN:   if (!buf_full || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any) req_ready[grant_idx] = 1'b1;
    gen_reset = __reset || (state == IDLE) || (state == GRST) || (state == DRAIN);
    gen_start = (state == LOAD);
    gen_ready = (state == RUN) && !abort && (!buf_full || out_ready);
    busy      = (state != IDLE);
  end

  always_ff @(posedge __clock or posedge __reset) begin
    if (__reset) begin
      rr_ptr    <= '0;
      job_id    <= '0;
      gen_n     <= '0;
      rst_cnt   <= '0;
      wd_cnt    <= '0;
      done_seen <= 1'b0;
      buf_full  <= 1'b0;
      buf_data  <= '0;
      buf_id    <= '0;
      buf_last  <= 1'b0;
      buf_err   <= 1'b0;
    end else begin
      if (state == IDLE && grant_any) begin
        gen_n     <= req_n[grant_idx*DW +: DW];
        job_id    <= grant_idx;
        rr_ptr    <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        rst_cnt   <= RW'(GEN_RST_CYCLES - 1);
        done_seen <= 1'b0;
      end

      if (state == GRST && rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;

      if (state == LOAD) begin
        wd_cnt <= WW'(TIMEOUT);
      end else if (state == RUN) begin
        if (gen_valid)          wd_cnt <= WW'(TIMEOUT);
        else if (wd_cnt != '0)  wd_cnt <= wd_cnt - 1'b1;
      end

      // The core drops done after one cycle, so remember it even while stalled.
      if (state == RUN && gen_valid && gen_done) done_seen <= 1'b1;

      if (cap) begin
        buf_full <= 1'b1;
        buf_data <= gen_data;
        buf_id   <= job_id;
        buf_last <= cap_last;
        buf_err  <= 1'b0;
      end else if (abort) begin
        buf_full <= 1'b1;
        buf_data <= '0;
        buf_id   <= job_id;
        buf_last <= 1'b1;
        buf_err  <= 1'b1;
      end else if (drain) begin
        buf_full <= 1'b0;
      end
    end
  end

  assign out_valid = buf_full;
  assign out_data  = buf_data;
  assign out_id    = buf_id;
  assign out_last  = buf_last;
  assign out_err   = buf_err;

endmodule

// File: tb/tb_gen_share_arbiter.sv
// Scoreboard bench for gen_share_arbiter driving a behavioural odd-Fibonacci generator core.
module tb_gen_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int IW      = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_n;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  gen_reset, gen_start, gen_ready;
  logic [DW-1:0]         gen_n;
  logic                  gen_valid, gen_done;
  logic [DW-1:0]         gen_data;
  logic                  out_valid, out_ready, out_last, out_err, busy;
  logic [DW-1:0]         out_data;
  logic [IW-1:0]         out_id;

  always #5 clk = ~clk;

  gen_share_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .GEN_RST_CYCLES(2), .TIMEOUT(16)) dut (
    .__clock(clk), .__reset(rst),
    .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .gen_reset(gen_reset), .gen_start(gen_start), .gen_n(gen_n), .gen_ready(gen_ready),
    .gen_valid(gen_valid), .gen_done(gen_done), .gen_data(gen_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .out_last(out_last), .out_err(out_err), .busy(busy)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          last;
    logic          err;
  } beat_t;

  beat_t sb[$];
  int    grant_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    beats_seen = 0;
  int    grants_seen = 0;
  int    grant_cyc = 0, start_cyc = 0, ov_rise_cyc = 0;
  int    ready_mode = 0;
  logic  core_mute = 1'b0;
  logic  prev_ov = 1'b0;
  beat_t exp_b;
  int    exp_g;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural core: emits the odd Fibonacci numbers below n, then a 0 terminator with done.
  int   cq[$];
  logic crun;

  function automatic void core_fill(input logic [DW-1:0] n);
    longint a, b, t;
    a = 1; b = 1;
    cq.delete();
    while (a < n) begin
      if (a % 2 == 1) cq.push_back(int'(a));
      t = a + b; a = b; b = t;
    end
    cq.push_back(0);
  endfunction

  always @(posedge clk) begin
    if (gen_reset) begin
      gen_valid <= 1'b0;
      gen_done  <= 1'b0;
      gen_data  <= '0;
      crun      <= 1'b0;
      cq.delete();
    end else begin
      gen_done <= 1'b0;
      if (gen_start) begin
        core_fill(gen_n);
        crun <= 1'b1;
      end else if (crun && !core_mute && (!gen_valid || gen_ready)) begin
        if (cq.size() > 0) begin
          gen_data  <= DW'(cq[0]);
          gen_valid <= 1'b1;
          gen_done  <= (cq.size() == 1);
          cq.pop_front();
        end else begin
          gen_valid <= 1'b0;
          crun      <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_ov) ov_rise_cyc = cyc;
      if (gen_start) start_cyc = cyc;
      if (out_valid && out_ready) begin
        beats_seen++;
        if (sb.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          exp_b = sb.pop_front();
          chk("beat_data", out_data, exp_b.data);
          chk("beat_id",   out_id,   exp_b.id);
          chk("beat_last", out_last, exp_b.last);
          chk("beat_err",  out_err,  exp_b.err);
        end
      end
      if (req_ready != '0) begin
        grants_seen++;
        grant_cyc = cyc;
        if (grant_q.size() == 0) chk("grant_unexpected", 1, 0);
        else begin
          exp_g = grant_q.pop_front();
          chk("grant_onehot", req_ready, 64'(1) << exp_g);
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic push_beat(input int data, input int id, input bit last, input bit err);
    beat_t b;
    b.data = DW'(data); b.id = IW'(id); b.last = last; b.err = err;
    sb.push_back(b);
  endtask

  task automatic push_job10(input int id);
    push_beat(1, id, 0, 0); push_beat(1, id, 0, 0); push_beat(3, id, 0, 0);
    push_beat(5, id, 0, 0); push_beat(0, id, 1, 0);
  endtask

  task automatic request(input int id, input int n);
    int g0;
    g0 = grants_seen;
    @(posedge clk); #1;
    req_n[id*DW +: DW] = DW'(n);
    req_valid[id] = 1'b1;
    for (int t = 0; t < 200 && grants_seen == g0; t++) begin
      @(posedge clk); #1;
    end
    if (grants_seen == g0) chk("grant_timeout", 0, 1);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while ((busy || sb.size() != 0) && t < 400);
    if (t >= 400) chk({tag, "_idle_timeout"}, 0, 1);
    else          chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int g0, b0;
    rst = 1'b1; req_valid = '0; req_n = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gen_reset", gen_reset, 1);
    chk("rst_gen_start", gen_start, 0);
    chk("rst_gen_ready", gen_ready, 0);
    chk("rst_gen_n",     gen_n,     0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_id",    out_id,    0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_out_err",   out_err,   0);
    chk("rst_busy",      busy,      0);
    rst = 1'b0;

    // n=0 from requester 1: lone terminator beat, start three cycles after grant.
    grant_q.push_back(1); push_beat(0, 1, 1, 0);
    request(1, 0);
    wait_idle("t1");
    chk("t1_start_latency", start_cyc - grant_cyc, 3);

    // n=10 from requester 0 at full throughput.
    grant_q.push_back(0); push_job10(0);
    request(0, 10);
    wait_idle("t2");

    // Same job with consumer accepting one cycle in three.
    ready_mode = 1;
    grant_q.push_back(0); push_job10(0);
    request(0, 10);
    wait_idle("t3");
    ready_mode = 0;

    // Silent core: watchdog abort beat.
    core_mute = 1'b1;
    grant_q.push_back(3); push_beat(0, 3, 1, 1);
    request(3, 10);
    wait_idle("t5");
    chk("t5_abort_delay", ov_rise_cyc - (start_cyc + 1), 17);
    core_mute = 1'b0;

    // Round robin with three held requesters, from a freshly reset pointer.
    do_reset();
    g0 = grants_seen;
    grant_q.push_back(0); grant_q.push_back(2); grant_q.push_back(3); grant_q.push_back(0);
    for (int k = 0; k < 4; k++) begin
      int rid;
      rid = (k == 1) ? 2 : (k == 2) ? 3 : 0;
      push_beat(1, rid, 0, 0); push_beat(1, rid, 0, 0); push_beat(0, rid, 1, 0);
    end
    @(posedge clk); #1;
    req_n[0*DW +: DW] = 2; req_n[2*DW +: DW] = 2; req_n[3*DW +: DW] = 2;
    req_valid = 4'b1101;
    for (int t = 0; t < 400 && grants_seen < g0 + 4; t++) begin
      @(posedge clk); #1;
    end
    if (grants_seen < g0 + 4) chk("t4_grant_timeout", 0, 1);
    req_valid = '0;
    wait_idle("t4");

    // Reset in the middle of a job, then a clean job.
    b0 = beats_seen;
    grant_q.push_back(2); push_job10(2);
    request(2, 10);
    for (int t = 0; t < 200 && beats_seen < b0 + 2; t++) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_busy",      busy,      0);
    chk("t6_gen_reset", gen_reset, 1);
    chk("t6_gen_ready", gen_ready, 0);
    chk("t6_gen_n",     gen_n,     0);
    chk("t6_out_data",  out_data,  0);
    sb.delete(); grant_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    grant_q.push_back(0); push_job10(0);
    request(0, 10);
    wait_idle("t6b");

    chk("end_sb_empty",    sb.size(), 0);
    chk("end_grant_empty", grant_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
